alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 16-bit ALU, generalised in datapath width and scratch-memory depth.
- Adds a valid/ready handshake on both input and output, and registered results and flags (N, Z, C, V, DZ).
- MUL and DIV use shift-add and restoring-division engines that iterate over W cycles; all other operations complete in one cycle.
- Sits between the register file and the writeback stage of the processor.

Parameters:
W, 16, datapath width in bits; must be at least 4.
DEPTH, 256, number of scratch-memory words; must be a power of 2.
AW, $clog2(DEPTH), scratch-memory address width (derived).

Ports:
clk  input  1  clock; everything is sampled on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  an operation is presented
in_ready  output  1  the block accepts an operation this cycle
opcode  input  4  operation code (encoding below)
r  input  W  operand R
s  input  W  operand S; s[AW-1:0] is the address for LD/ST
out_valid  output  1  a result is held on the outputs
out_ready  input  1  the consumer takes the result
out  output  W  result
flag_n  output  1  negative: out[W-1]
flag_z  output  1  zero: out == 0, compared across all W bits
flag_c  output  1  carry / borrow / MUL overflow
flag_v  output  1  signed overflow (ADD, SUB, INC, DEC only)
flag_dz  output  1  divide-by-zero
busy  output  1  the block is in state EXEC or DONE

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 INC, 5 DEC, 6 AND, 7 OR, 8 XOR, 9 NOT, A LD, B ST, F PASS. All other codes behave as PASS.
- Arithmetic width rules:
  - ADD and INC: the sum is W+1 bits; C is the carry out of bit W-1.
  - SUB and DEC: C=1 on borrow, i.e. unsigned r < s (or r == 0 for DEC).
  - V follows two's-complement overflow rules.
- MUL: out = low W bits of the unsigned product; C = OR of the high W bits. Latency is W cycles in EXEC.
- DIV: out = unsigned quotient; remainder is discarded. Latency is W cycles in EXEC.
- DIV with s == 0: skip EXEC; out = all ones, DZ=1, C=0.
- Logic ops (AND, OR, XOR, NOT), LD and PASS: C=0, V=0.
- LD: out = mem[s[AW-1:0]].
- ST: writes mem[s[AW-1:0]] = r in the accept cycle; out = r; C=0, V=0.
- N and Z are derived from out for every opcode. DZ=0 for every operation other than divide-by-zero.
- FSM states:
  - IDLE: in_ready=1. On in_valid: MUL/DIV go to EXEC with an iteration counter of 0; all other ops latch their result and go to DONE.
  - EXEC: one iteration per cycle; the counter increments. When counter == W-1, latch the result and go to DONE.
  - DONE: out_valid=1 and outputs are stable. If out_ready=0, hold indefinitely.
  - DONE with out_ready=1: in_ready=1 in the same cycle. With in_valid also high, accept the new op back-to-back (to EXEC or DONE); otherwise go to IDLE.
- Latency, counting from the accept edge:
  - Single-cycle ops: out_valid at the next edge.
  - MUL/DIV: out_valid at edge +W+1 (accept edge, plus W EXEC edges).
- Operands and opcode are captured at accept. Changes on the input ports afterwards have no effect on the operation in flight.
- in_ready is 0 in EXEC. in_ready is 0 in DONE while out_ready=0.
- Reset:
  - out_valid=0, in_ready=1 once rst deasserts.
  - out=0 and all flags=0; state=IDLE; counter=0.
  - An in-flight MUL/DIV is aborted and produces no result.
  - Scratch memory is not reset.
- rst has priority over every other input in the same cycle.
- LD issued immediately after an ST to the same address returns the newly stored data. The write happens at the ST accept edge, before the LD reads.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (OP_ADD..OP_PASS);
  - the state encoding (ST_IDLE, ST_EXEC, ST_DONE);
  - the flag bundle bit positions.
- One sub-module, alu_seq_muldiv, holds the iterative engine: start, mode, a, b in; done, result, overflow out; W-cycle fixed latency. The single-cycle ops, the memory and the FSM stay in alu_seq.

Test Plan:
- ADD r=0xFFFF, s=0x0001 (W=16) -> next cycle: out=0x0000, C=1, Z=1, N=0, V=0.
- SUB r=3, s=5 -> out=0xFFFE, C=1, N=1, Z=0. Then ADD r=0x7FFF, s=1 -> out=0x8000, V=1, N=1.
- MUL r=0x0100, s=0x0100 -> out_valid exactly 17 cycles after accept, out=0x0000, C=1, Z=1. MUL r=12, s=11 -> out=132, C=0.
- DIV r=100, s=7 -> out=14 after 17 cycles, DZ=0. DIV r=5, s=0 -> next cycle: out=0xFFFF, DZ=1.
- ST r=0xBEEF, s=0x0042, then LD s=0x0042 back-to-back with out_ready=1 -> out=0xBEEF. Hold out_ready=0 for 5 cycles -> out, flags and out_valid stay stable and in_ready=0.
- Start DIV r=1000, s=3; assert rst at EXEC cycle 6 -> the next cycle shows state IDLE, out_valid=0, out=0, all flags 0, and no result ever appears for the aborted op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-bundle definitions for the sequential ALU.
// Also holds the engine mode encoding and a flag-packing helper.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_INC  = 4'h4;
   localparam logic [3:0] OP_DEC  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_LD   = 4'hA;
   localparam logic [3:0] OP_ST   = 4'hB;
   localparam logic [3:0] OP_PASS = 4'hF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int FLAG_N    = 0;
   localparam int FLAG_Z    = 1;
   localparam int FLAG_C    = 2;
   localparam int FLAG_V    = 3;
   localparam int FLAG_DZ   = 4;
   localparam int NUM_FLAGS = 5;

   localparam logic MD_MUL = 1'b0;
   localparam logic MD_DIV = 1'b1;

   function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic n, input logic z,
                                                       input logic c, input logic v,
                                                       input logic dz);
      logic [NUM_FLAGS-1:0] f;
      f          = '0;
      f[FLAG_N]  = n;
      f[FLAG_Z]  = z;
      f[FLAG_C]  = c;
      f[FLAG_V]  = v;
      f[FLAG_DZ] = dz;
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo register pair.
// Runs exactly W iterations after start; result and overflow are valid while done is high.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] result,
   output logic         overflow
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic          running;
   logic          mode_q;
   logic [CW-1:0] cnt;
   logic [W-1:0]  hi, lo, b_q;
   logic [W-1:0]  nhi, nlo;
   logic [W:0]    sum, shifted, diff;

   // MUL: hi:lo shifts right with a conditional add; DIV: remainder:quotient shifts left.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      shifted = {hi, lo[W-1]};
      diff    = shifted - {1'b0, b_q};
      if (mode_q == MD_MUL) begin
         nhi = sum[W:1];
         nlo = {sum[0], lo[W-1:1]};
      end else if (!diff[W]) begin
         nhi = diff[W-1:0];
         nlo = {lo[W-2:0], 1'b1};
      end else begin
         nhi = shifted[W-1:0];
         nlo = {lo[W-2:0], 1'b0};
      end
   end

   // The result of the final iteration is presented combinationally so the
   // caller can latch it on the same edge that completes iteration W-1.
   assign done     = running && (cnt == CW'(W - 1));
   assign result   = nlo;
   assign overflow = (mode_q == MD_MUL) && (|nhi);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         cnt     <= '0;
         mode_q  <= MD_MUL;
         hi      <= '0;
         lo      <= '0;
         b_q     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         mode_q  <= mode;
         hi      <= '0;
         lo      <= a;
         b_q     <= b;
      end else if (running) begin
         hi <= nhi;
         lo <= nlo;
         if (done) begin
            running <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes, registered result and N/Z/C/V/DZ flags,
// a scratch memory for LD/ST, and an iterative engine for MUL/DIV.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   opcode,
   input  logic [W-1:0] r,
   input  logic [W-1:0] s,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         flag_n,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_v,
   output logic         flag_dz,
   output logic         busy
);

   logic [1:0]           state;
   logic [NUM_FLAGS-1:0] flags;
   logic [W-1:0]         mem [DEPTH];

   logic         accept, is_div, div_zero, md_start, md_done, md_ovf;
   logic [W-1:0] md_result, res, b_op, rd_data;
   logic [W:0]   ext;
   logic         c_res, v_res;

   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign is_div    = (opcode == OP_DIV);
   assign div_zero  = (s == '0);
   assign md_start  = accept && ((opcode == OP_MUL) || (is_div && !div_zero));
   assign rd_data   = mem[s[AW-1:0]];

   assign flag_n  = flags[FLAG_N];
   assign flag_z  = flags[FLAG_Z];
   assign flag_c  = flags[FLAG_C];
   assign flag_v  = flags[FLAG_V];
   assign flag_dz = flags[FLAG_DZ];

   alu_seq_muldiv #(.W(W)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start    (md_start),
      .mode     (is_div ? MD_DIV : MD_MUL),
      .a        (r),
      .b        (s),
      .done     (md_done),
      .result   (md_result),
      .overflow (md_ovf)
   );

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      b_op  = ((opcode == OP_INC) || (opcode == OP_DEC)) ? W'(1) : s;
      res   = r;
      ext   = '0;
      c_res = 1'b0;
      v_res = 1'b0;
      case (opcode)
         OP_ADD, OP_INC: begin
            ext   = {1'b0, r} + {1'b0, b_op};
            res   = ext[W-1:0];
            c_res = ext[W];
            v_res = (r[W-1] == b_op[W-1]) && (res[W-1] != r[W-1]);
         end
         OP_SUB, OP_DEC: begin
            ext   = {1'b0, r} - {1'b0, b_op};
            res   = ext[W-1:0];
            c_res = ext[W];
            v_res = (r[W-1] != b_op[W-1]) && (res[W-1] != r[W-1]);
         end
         OP_AND:  res = r & s;
         OP_OR:   res = r | s;
         OP_XOR:  res = r ^ s;
         OP_NOT:  res = ~r;
         OP_LD:   res = rd_data;
         default: res = r;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         out   <= '0;
         flags <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (md_start) begin
                     state <= ST_EXEC;
                  end else if (is_div) begin
                     out   <= '1;
                     flags <= pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                     state <= ST_DONE;
                  end else begin
                     out   <= res;
                     flags <= pack_flags(res[W-1], res == '0, c_res, v_res, 1'b0);
                     state <= ST_DONE;
                  end
               end else if ((state == ST_DONE) && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (md_done) begin
                  out   <= md_result;
                  flags <= pack_flags(md_result[W-1], md_result == '0, md_ovf, 1'b0, 1'b0);
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the scratch memory has no reset; contents survive rst and start undefined.
   always_ff @(posedge clk) begin
      if (!rst && accept && (opcode == OP_ST)) begin
         mem[s[AW-1:0]] <= r;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table plus hand-written handshake,
// memory and abort sequences, with a scoreboard queue of expected results.
module tb_alu_seq;

   localparam int W     = 16;
   localparam int DEPTH = 256;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] r;
   logic [W-1:0] s;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         flag_n, flag_z, flag_c, flag_v, flag_dz;
   logic         busy;

   always #5 clk = ~clk;

   alu_seq #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .r         (r),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_dz   (flag_dz),
      .busy      (busy)
   );

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_out;
      logic [4:0]   exp_flags;
      int           exp_lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] out;
      logic [4:0]   flags;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs [24];
   int   checks = 0;
   int   errors = 0;

   // Flag bundle as {dz, v, c, z, n}
   function automatic logic [4:0] fl(input logic n, input logic z, input logic c,
                                     input logic v, input logic dz);
      return {dz, v, c, z, n};
   endfunction

   function automatic logic [4:0] dut_flags();
      return {flag_dz, flag_v, flag_c, flag_z, flag_n};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic collect(input string name, input int lat);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check({name, "_out"}, 32'(out), 32'(e.out));
      check({name, "_flags"}, 32'(dut_flags()), 32'(e.flags));
      check({name, "_lat"}, 32'(lat), 32'(e.lat));
   endtask

   // Issue one op, scramble the inputs after accept, measure edges to out_valid.
   task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo,
                         input logic [4:0] ef, input int el);
      int lat;
      sb_q.push_back('{out: eo, flags: ef, lat: el});
      @(negedge clk);
      out_ready = 1'b0;
      opcode    = op;
      r         = a;
      s         = b;
      in_valid  = 1'b1;
      #1;
      for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      opcode   = 4'(($urandom % 16));
      r        = W'($urandom);
      s        = W'($urandom);
      lat      = 1;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      collect(name, lat);
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;

      vecs[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, fl(0,1,1,0,0), 1};
      vecs[1]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, fl(1,0,1,0,0), 1};
      vecs[2]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, fl(1,0,0,1,0), 1};
      vecs[3]  = '{4'h2, 16'h0100, 16'h0100, 16'h0000, fl(0,1,1,0,0), 17};
      vecs[4]  = '{4'h2, 16'h000C, 16'h000B, 16'h0084, fl(0,0,0,0,0), 17};
      vecs[5]  = '{4'h3, 16'h0064, 16'h0007, 16'h000E, fl(0,0,0,0,0), 17};
      vecs[6]  = '{4'h3, 16'h0005, 16'h0000, 16'hFFFF, fl(1,0,0,0,1), 1};
      vecs[7]  = '{4'h4, 16'hFFFF, 16'h1234, 16'h0000, fl(0,1,1,0,0), 1};
      vecs[8]  = '{4'h4, 16'h7FFF, 16'h0000, 16'h8000, fl(1,0,0,1,0), 1};
      vecs[9]  = '{4'h5, 16'h0000, 16'h5555, 16'hFFFF, fl(1,0,1,0,0), 1};
      vecs[10] = '{4'h5, 16'h8000, 16'h0000, 16'h7FFF, fl(0,0,0,1,0), 1};
      vecs[11] = '{4'h6, 16'hF0F0, 16'h3C3C, 16'h3030, fl(0,0,0,0,0), 1};
      vecs[12] = '{4'h7, 16'hF0F0, 16'h0F00, 16'hFFF0, fl(1,0,0,0,0), 1};
      vecs[13] = '{4'h8, 16'hAAAA, 16'hAAAA, 16'h0000, fl(0,1,0,0,0), 1};
      vecs[14] = '{4'h9, 16'h00FF, 16'h1234, 16'hFF00, fl(1,0,0,0,0), 1};
      vecs[15] = '{4'hF, 16'h1234, 16'hFFFF, 16'h1234, fl(0,0,0,0,0), 1};
      vecs[16] = '{4'hC, 16'h8001, 16'h0000, 16'h8001, fl(1,0,0,0,0), 1};
      vecs[17] = '{4'h1, 16'h0005, 16'h0005, 16'h0000, fl(0,1,0,0,0), 1};
      vecs[18] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, fl(0,0,1,0,0), 17};
      vecs[19] = '{4'h3, 16'hFFFF, 16'h0001, 16'hFFFF, fl(1,0,0,0,0), 17};
      vecs[20] = '{4'h3, 16'h0007, 16'h0009, 16'h0000, fl(0,1,0,0,0), 17};
      vecs[21] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, fl(0,0,0,1,0), 1};
      vecs[22] = '{4'h2, 16'h0000, 16'h1234, 16'h0000, fl(0,1,0,0,0), 17};
      vecs[23] = '{4'h3, 16'h03E8, 16'h0003, 16'h014D, fl(0,0,0,0,0), 17};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = 4'h0;
      r         = '0;
      s         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_flags", 32'(dut_flags()), 32'd0);

      for (int i = 0; i < 24; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_out, vecs[i].exp_flags, vecs[i].exp_lat);
      end

      // ST then LD to the same address back-to-back, then a held output.
      run_op("st", 4'hB, 16'hBEEF, 16'h0042, 16'hBEEF, fl(1,0,0,0,0), 1);
      sb_q.push_back('{out: 16'hBEEF, flags: fl(1,0,0,0,0), lat: 1});
      opcode   = 4'hA;
      r        = 16'h0000;
      s        = 16'h0042;
      in_valid = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      opcode    = 4'h0;
      r         = 16'h1111;
      s         = 16'h2222;
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      collect("ld_b2b", 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_out", k), 32'(out), 32'h0000BEEF);
         check($sformatf("hold%0d_flags", k), 32'(dut_flags()), 32'(fl(1,0,0,0,0)));
         check($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // DIV aborted by reset in its sixth EXEC cycle must never produce a result.
      @(negedge clk);
      out_ready = 1'b0;
      opcode    = 4'h3;
      r         = 16'd1000;
      s         = 16'd3;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy_cleared", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out", 32'(out), 32'd0);
      check("abort_flags", 32'(dut_flags()), 32'd0);
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);

      run_op("ld_after_rst", 4'hA, 16'h0000, 16'h0042, 16'hBEEF, fl(1,0,0,0,0), 1);
      run_op("add_after_rst", 4'h0, 16'h0001, 16'h0002, 16'h0003, fl(0,0,0,0,0), 1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
